// File: rtl/cmd_tx.sv
// Serialises one write/tick command per handshake into ASCII bytes for the simulation I/O parser.
// Optional feature macro: CMD_TX_HACK_EN (type 3 emits "h\n"; otherwise type 3 is accepted and dropped).
`timescale 1ns/1ps
module cmd_tx #(
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_type,
  input  logic [1:0]    cmd_id,
  input  logic [3:0]    cmd_index,
  input  logic [VW-1:0] cmd_value,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy
);
  localparam int ND = (VW * 301 + 999) / 1000;
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(VW + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_OP, S_SP1, S_ID1, S_ID0, S_SP2, S_IDX1, S_IDX0,
    S_SP3, S_BIN, S_CONV, S_DEC, S_NL
  } state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic [1:0]    r_type;
  logic [1:0]    r_id;
  logic [3:0]    r_idx;
  logic [VW-1:0] r_val;
  logic [BW-1:0] r_bcd;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_fire;
  logic          w_drop;
  logic [BW-1:0] w_bcd_step;
  logic [BW-1:0] w_bcd_align;
  logic [BW-1:0] w_bcd_sh;
  logic [CW-1:0] w_nsig;

  // One double-dabble step: correct every BCD digit, then shift in the next binary bit.
  function automatic logic [BW-1:0] f_dabble(input logic [BW-1:0] b, input logic bit_in);
    logic [BW-1:0] a;
    a = b;
    for (int i = 0; i < ND; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[BW-2:0], bit_in};
  endfunction

  // Number of significant decimal digits; zero still counts as one digit.
  function automatic logic [CW-1:0] f_nsig(input logic [BW-1:0] b);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int i = 0; i < ND; i++)
      if (b[4*i +: 4] != 4'd0) n = CW'(i + 1);
    return n;
  endfunction

  function automatic logic [7:0] f_op(input logic [1:0] t);
    case (t)
      2'd0:    return 8'h62;
      2'd1:    return 8'h66;
      2'd2:    return 8'h74;
      default: return 8'h68;
    endcase
  endfunction

  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_fire      = r_tx_valid & tx_ready;
`ifdef CMD_TX_HACK_EN
  assign w_drop      = 1'b0;
`else
  assign w_drop      = (cmd_type == 2'd3);
`endif
  assign w_bcd_step  = f_dabble(r_bcd, r_val[VW-1]);
  assign w_nsig      = f_nsig(w_bcd_step);
  // Left-align the most significant non-zero digit so DEC always emits from the top nibble.
  assign w_bcd_align = w_bcd_step << (4 * (ND - int'(w_nsig)));
  assign w_bcd_sh    = r_bcd << 4;

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_type      <= 2'd0;
      r_id        <= 2'd0;
      r_idx       <= 4'd0;
      r_val       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type      <= cmd_type;
            r_id        <= cmd_id;
            r_idx       <= cmd_index;
            r_val       <= cmd_value;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (!w_drop) begin
              r_state    <= S_OP;
              r_tx_valid <= 1'b1;
              r_tx_data  <= f_op(cmd_type);
            end
          end else begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_OP: if (w_fire) begin
          if (r_type[1]) begin
            r_state   <= S_NL;
            r_tx_data <= 8'h0A;
          end else begin
            r_state   <= S_SP1;
            r_tx_data <= 8'h20;
          end
        end
        S_SP1: if (w_fire) begin
          r_state   <= S_ID1;
          r_tx_data <= {7'h18, r_id[1]};
        end
        S_ID1: if (w_fire) begin
          r_state   <= S_ID0;
          r_tx_data <= {7'h18, r_id[0]};
        end
        S_ID0: if (w_fire) begin
          r_state   <= S_SP2;
          r_tx_data <= 8'h20;
        end
        S_SP2: if (w_fire) begin
          if (r_idx >= 4'd10) begin
            r_state   <= S_IDX1;
            r_tx_data <= 8'h31;
          end else begin
            r_state   <= S_IDX0;
            r_tx_data <= {4'h3, r_idx};
          end
        end
        S_IDX1: if (w_fire) begin
          r_state   <= S_IDX0;
          r_tx_data <= {4'h3, r_idx - 4'd10};
        end
        S_IDX0: if (w_fire) begin
          r_state   <= S_SP3;
          r_tx_data <= 8'h20;
        end
        S_SP3: if (w_fire) begin
          if (r_type == 2'd0) begin
            r_state   <= S_BIN;
            r_tx_data <= {7'h18, r_val[VW-1]};
            r_val     <= r_val << 1;
            r_cnt     <= CW'(VW - 1);
          end else begin
            r_state    <= S_CONV;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_bcd      <= '0;
            r_cnt      <= CW'(VW);
          end
        end
        S_BIN: if (w_fire) begin
          if (r_cnt == '0) begin
            r_state   <= S_NL;
            r_tx_data <= 8'h0A;
          end else begin
            r_tx_data <= {7'h18, r_val[VW-1]};
            r_val     <= r_val << 1;
            r_cnt     <= r_cnt - CW'(1);
          end
        end
        S_CONV: begin
          r_val <= r_val << 1;
          if (r_cnt == CW'(1)) begin
            r_state    <= S_DEC;
            r_bcd      <= w_bcd_align;
            r_cnt      <= w_nsig - CW'(1);
            r_tx_valid <= 1'b1;
            r_tx_data  <= {4'h3, w_bcd_align[BW-1 -: 4]};
          end else begin
            r_bcd <= w_bcd_step;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DEC: if (w_fire) begin
          if (r_cnt == '0) begin
            r_state   <= S_NL;
            r_tx_data <= 8'h0A;
          end else begin
            r_bcd     <= w_bcd_sh;
            r_tx_data <= {4'h3, w_bcd_sh[BW-1 -: 4]};
            r_cnt     <= r_cnt - CW'(1);
          end
        end
        S_NL: if (w_fire) begin
          r_state     <= S_IDLE;
          r_tx_valid  <= 1'b0;
          r_tx_data   <= 8'h00;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_tx.sv
// Directed bench for cmd_tx: byte streams, handshake timing, stalls, reset and type-3 handling.
`timescale 1ns/1ps
module tb_cmd_tx;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_type = 2'd0;
  logic [1:0]    cmd_id = 2'd0;
  logic [3:0]    cmd_index = 4'd0;
  logic [VW-1:0] cmd_value = '0;
  logic          tx_ready = 1'b1;
  logic          cmd_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  int         gap = 0;
  bit         stall_mode = 1'b0;
  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h00;
  int         s0;
  int         g0;

  cmd_tx #(.VW(VW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_id(cmd_id), .cmd_index(cmd_index), .cmd_value(cmd_value),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink: ready changes just after each rising edge; bytes are logged mid-cycle.
  always @(posedge clk) begin
    #2;
    tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check_vec("stall_hold_data", tx_data, held_d);
        check_vec("stall_hold_vld", tx_valid, 1);
      end
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (busy && !tx_valid) gap++;
    end
  end

  task automatic send(input logic [1:0] t, input logic [1:0] id, input logic [3:0] idx,
                      input logic [VW-1:0] val);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_vec("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_id    = id;
    cmd_index = idx;
    cmd_value = val;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_id    = 2'($urandom);
    cmd_index = 4'($urandom);
    cmd_value = VW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_vec("idle_timeout", {31'b0, cmd_ready & ~busy}, 1);
  endtask

  task automatic check_line(input string tag, input string exp, input int start);
    check_vec({tag, "_len"}, q.size() - start, exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (start + i < q.size()) check_vec(tag, q[start + i], exp[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_vec("rst_cmd_ready", cmd_ready, 0);
    check_vec("rst_tx_valid", tx_valid, 0);
    check_vec("rst_tx_data", tx_data, 8'h00);
    check_vec("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check_vec("post_rst_ready", cmd_ready, 1);
    check_vec("post_rst_busy", busy, 0);

    s0 = q.size();
    send(2'd2, 2'd0, 4'd0, '0);
    @(negedge clk);
    check_vec("t_b0_vld", tx_valid, 1);
    check_vec("t_b0_data", tx_data, 8'h74);
    check_vec("t_ready_low", cmd_ready, 0);
    check_vec("t_busy_high", busy, 1);
    @(negedge clk);
    check_vec("t_b1_vld", tx_valid, 1);
    check_vec("t_b1_data", tx_data, 8'h0A);
    @(negedge clk);
    check_vec("t_end_vld", tx_valid, 0);
    check_vec("t_end_ready", cmd_ready, 1);
    check_vec("t_end_busy", busy, 0);
    check_line("t_line", "t\n", s0);

    s0 = q.size();
    send(2'd0, 2'd2, 4'd5, 16'h0001);
    wait_idle(200);
    check_line("b_line", "b 10 5 0000000000000001\n", s0);

    s0 = q.size(); g0 = gap;
    send(2'd1, 2'd1, 4'd12, 16'd65535);
    wait_idle(200);
    check_line("f_max", "f 01 12 65535\n", s0);
    check_vec("f_max_gap", gap - g0, 16);

    s0 = q.size(); g0 = gap;
    send(2'd1, 2'd1, 4'd12, 16'd0);
    wait_idle(200);
    check_line("f_zero", "f 01 12 0\n", s0);
    check_vec("f_zero_gap", gap - g0, 16);

    s0 = q.size();
    send(2'd1, 2'd0, 4'd7, 16'd1000);
    wait_idle(200);
    check_line("f_1000", "f 00 7 1000\n", s0);

    stall_mode = 1'b1;
    s0 = q.size();
    send(2'd0, 2'd3, 4'd10, 16'hA5C3);
    wait_idle(1000);
    stall_mode = 1'b0;
    check_line("b_stall", "b 11 10 1010010111000011\n", s0);

    s0 = q.size();
    send(2'd0, 2'd1, 4'd3, 16'hFFFF);
    repeat (12) @(negedge clk);
    check_vec("pre_rst_vld", tx_valid, 1);
    #1 rst = 1'b0;
    #1;
    check_vec("midrst_vld", tx_valid, 0);
    check_vec("midrst_ready", cmd_ready, 0);
    check_vec("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s0 = q.size();
    send(2'd2, 2'd0, 4'd0, '0);
    wait_idle(200);
    check_line("t_after_rst", "t\n", s0);

    s0 = q.size();
    send(2'd3, 2'd2, 4'd9, 16'h1234);
`ifdef CMD_TX_HACK_EN
    wait_idle(200);
    check_line("h_line", "h\n", s0);
`else
    @(negedge clk);
    check_vec("h_drop_busy", busy, 1);
    check_vec("h_drop_ready0", cmd_ready, 0);
    check_vec("h_drop_vld", tx_valid, 0);
    @(negedge clk);
    check_vec("h_drop_ready1", cmd_ready, 1);
    check_vec("h_drop_busy0", busy, 0);
    repeat (8) @(negedge clk);
    check_vec("h_drop_bytes", q.size() - s0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cmd_tx.md
# cmd_tx

Command-stream transmitter, the sending end of the ASCII command protocol that the simulation I/O parser consumes. It accepts one write/tick command per handshake and serialises it into bytes: `b <id> <index> <value>\n`, `f <id> <index> <value>\n` or `t\n`. Bytes leave one per accepted beat on a valid/ready byte interface. It sits between the client-side command source and the byte channel feeding the parser's STDIN.

## Interface
- VW, 16: value width in bits; binary field is VW digits, decimal field is at most ceil(VW·log10 2) digits.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  2  0=`b`, 1=`f`, 2=`t`, 3=`h`.
- cmd_id  in  2  component ID.
- cmd_index  in  4  variable index, 0..15.
- cmd_value  in  VW  value, unsigned.
- tx_data  out  8  ASCII byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- busy  out  1  high from acceptance until the last byte is accepted.

## Operation
- Command fields are captured into internal registers on accept. Inputs may change afterwards.
- State machine:
  - IDLE: cmd_ready=1. On accept, go to OP.
  - OP: emits `b`/`f`/`t`/`h`.
    - `t` → NL.
    - `b`/`f` → SP1.
  - SP1: emits 0x20 → ID1.
  - ID1, ID0: emit id[1], id[0] as `0`/`1` → SP2.
  - SP2: emits 0x20 → IDX.
  - IDX: emits index in decimal, no leading zero; 10..15 takes two bytes (`1`, then units) → SP3.
  - SP3: emits 0x20.
    - `b` → BIN.
    - `f` → CONV.
  - BIN: emits VW binary digits, MSB first, leading zeros kept → NL.
  - CONV: double-dabble binary→BCD, one shift per cycle, exactly VW cycles, tx_valid=0 throughout → DEC.
  - DEC: emits BCD digits MSB first, leading zeros suppressed; value 0 emits a single `0` → NL.
  - NL: emits 0x0A → IDLE.
- Type 3 handling is set by CMD_TX_HACK_EN (see Configuration).

## Timing
- Reset values: cmd_ready=0 while rst=0, then 1 (IDLE); tx_valid=0, tx_data=0x00, busy=0. All internal registers clear.
- Command accept: posedge with cmd_valid & cmd_ready. cmd_ready drops the next cycle.
- First byte: tx_valid=1 on the cycle after accept (1-cycle latency).
- Byte advance: a byte advances only on a posedge with tx_valid & tx_ready. tx_data is stable while tx_valid=1 & tx_ready=0.
- Back-to-back bytes: tx_ready held high gives one byte per cycle, except the VW-cycle gap in CONV.
- Next command: cmd_ready returns to 1 the cycle after the `\n` is accepted; busy falls in the same cycle. No overlap between commands.
- tx_valid never drops once raised until its byte is accepted.
- Reset mid-message: outputs clear immediately and the message is truncated. The sink must tolerate a partial line; the parser resynchronises on the next command letter.
- `b` message length: 7 + (index≥10) + VW + 1 bytes. VW=16, index 3 gives 24 bytes.

## Configuration
- CMD_TX_HACK_EN defined: type 3 emits `h\n` (2 bytes, OP→NL).
- CMD_TX_HACK_EN undefined: type 3 is accepted (one-cycle cmd_ready handshake completes) and silently dropped. No bytes are emitted, busy pulses for one cycle, and cmd_ready returns the following cycle.

## Test plan
- `t` command, tx_ready=1: exactly 0x74, 0x0A on consecutive cycles starting the cycle after accept; cmd_ready back after 3 cycles.
- `b`, id=2, index=5, value=0x0001, VW=16: bytes `b 10 5 0000000000000001\n` (24 bytes).
- `f`, id=1, index=12, value=65535: `f 01 12 ` then 16 idle cycles, then `65535\n`. Value 0 yields `f 01 12 0\n`.
- Random tx_ready stalls during a `b` command: byte sequence identical to the no-stall run, and tx_data is never changed while stalled.
- rst pulsed low mid-BIN: tx_valid=0 and cmd_ready=0 asynchronously. After release, the next `t` emits `t\n` cleanly.
- Type 3: with CMD_TX_HACK_EN, `h\n` is emitted. Without it, no tx_valid for 10 cycles and cmd_ready re-asserts 2 cycles after accept.
